// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receive demultiplexer with frame-sync lock/hunt tracking.
// Define TDM_DEMUX_FRAME_COHERENT_EN to publish all four channels together at frame end.
module tdm_demux4 #(
    parameter int W          = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2,
    output logic [W-1:0] ch3,
    output logic [3:0]   ch_strobe,
    output logic         frame_done,
    output logic         locked,
    output logic         sync_err
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [2:0]   miss_q, miss_d;
    logic [W-1:0] ch_q [4];
    logic [W-1:0] ch_d [4];
    logic [3:0]   strobe_q, strobe_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [1:0]   e;
    logic [2:0]   miss_inc;
    logic         wr;
`ifdef TDM_DEMUX_FRAME_COHERENT_EN
    logic [W-1:0] sh_q [4];
    logic [W-1:0] sh_d [4];
`endif

    assign e        = frame_sync ? 2'd0 : slot_q;
    assign miss_inc = (miss_q == 3'd7) ? 3'd7 : miss_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        miss_d   = miss_q;
        ch_d     = ch_q;
        strobe_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr       = 1'b0;
        if (din_valid && state_q == HUNT && frame_sync) begin
            wr      = 1'b1;
            state_d = LOCKED;
            slot_d  = 2'd1;
            miss_d  = '0;
        end else if (din_valid && state_q == LOCKED) begin
            wr     = 1'b1;
            slot_d = e + 2'd1;
            done_d = (e == 2'd3);
            if (slot_q == 2'd0) begin
                miss_d = frame_sync ? 3'd0 : miss_inc;
                // A missing sync that exhausts the budget drops lock; the sample still lands in ch0.
                if (!frame_sync && miss_inc >= 3'(MISS_LIMIT)) begin
                    state_d = HUNT;
                    err_d   = 1'b1;
                    slot_d  = 2'd0;
                    miss_d  = '0;
                end
            end else if (frame_sync) begin
                err_d  = 1'b1;
                miss_d = '0;
            end
        end
`ifdef TDM_DEMUX_FRAME_COHERENT_EN
        sh_d = sh_q;
        if (err_d)
            sh_d = '{default: '0};
        if (wr)
            sh_d[e] = din;
        if (done_d) begin
            ch_d     = sh_d;
            strobe_d = 4'b1111;
        end
`else
        if (wr) begin
            ch_d[e]     = din;
            strobe_d[e] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            miss_q   <= '0;
            ch_q     <= '{default: '0};
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef TDM_DEMUX_FRAME_COHERENT_EN
            sh_q     <= '{default: '0};
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            miss_q   <= miss_d;
            ch_q     <= ch_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef TDM_DEMUX_FRAME_COHERENT_EN
            sh_q     <= sh_d;
`endif
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign ch_strobe  = strobe_q;
    assign frame_done = done_q;
    assign sync_err   = err_q;
    assign locked     = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized scoreboard bench for tdm_demux4 (per-slot build).
// A sample-level reference model queues the expected output set for every cycle; a monitor compares.
module tb_tdm_demux4;
    localparam int ML = 2;

    logic       clk = 0, rst = 1, din_valid = 0, frame_sync = 0;
    logic [7:0] din = 0;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_strobe;
    logic       frame_done, locked, sync_err;

    tdm_demux4 #(.W(8), .MISS_LIMIT(ML)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch_strobe(ch_strobe),
        .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] chs;
        logic [3:0]  st;
        logic        dn;
        logic        er;
        logic        lk;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, failures = 0;
    logic [7:0] mch[4];
    int         mslot = 0, mmiss = 0;
    bit         mlk = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mch[i] = 0;
        mslot = 0; mmiss = 0; mlk = 0;
    endtask

    // Reference behaviour, one accepted sample at a time.
    task automatic step(input bit v, input bit fs, input logic [7:0] d);
        exp_t x;
        int   es;
        @(negedge clk);
        din_valid = v; frame_sync = fs; din = d;
        x = '0;
        if (v && !mlk && fs) begin
            mlk = 1; mslot = 1; mmiss = 0; mch[0] = d; x.st = 4'b0001;
        end else if (v && mlk) begin
            es = fs ? 0 : mslot;
            mch[es] = d;
            x.st = 4'(1 << es);
            x.dn = (es == 3);
            if (fs && mslot != 0) begin
                x.er = 1; mmiss = 0;
            end else if (mslot == 0) begin
                if (fs) mmiss = 0;
                else begin
                    mmiss = (mmiss + 1 > 7) ? 7 : mmiss + 1;
                    if (mmiss >= ML) begin mlk = 0; x.er = 1; mmiss = 0; end
                end
            end
            mslot = mlk ? (es + 1) % 4 : 0;
        end
        x.chs = {mch[3], mch[2], mch[1], mch[0]};
        x.lk  = mlk;
        q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("channels", {ch3, ch2, ch1, ch0}, x.chs);
            chk("ch_strobe", 32'(ch_strobe), 32'(x.st));
            chk("frame_done", 32'(frame_done), 32'(x.dn));
            chk("sync_err", 32'(sync_err), 32'(x.er));
            chk("locked", 32'(locked), 32'(x.lk));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; din_valid = 0; frame_sync = 0;
        #1;
        chk("rst_channels", {ch3, ch2, ch1, ch0}, 0);
        chk("rst_pulses", {ch_strobe, frame_done, sync_err, locked}, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic settle();
        step(0, 0, 0);
        @(posedge clk); #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        // Aligned frame from reset.
        step(1, 1, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
        settle();
        chk("frame1", {ch3, ch2, ch1, ch0}, 32'h44332211);
        // Unsynced samples in HUNT are dropped.
        do_reset();
        step(1, 0, 8'h5A); step(1, 0, 8'h6B); step(1, 0, 8'h7C);
        settle();
        chk("hunt_drop", {ch3, ch2, ch1, ch0, 7'd0, locked}, 0);
        // Early sync at slot 2 realigns.
        step(1, 1, 8'h01); step(1, 0, 8'h02); step(1, 1, 8'hAA); step(1, 0, 8'h55);
        settle();
        chk("realign", {ch1, ch0, 7'd0, locked}, {8'h55, 8'hAA, 8'd1});
        // Two frames without sync drop lock.
        step(1, 0, 8'h03); step(1, 0, 8'h04);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++) step(1, 0, 8'(8'h80 + 4 * f + s));
        settle();
        chk("drop", {ch0, 7'd0, locked}, {8'h84, 8'd0});
        // Bubbles inside a frame, then reset mid-frame.
        step(1, 1, 8'hC0); step(0, 0, 8'hFF); step(1, 0, 8'hC1); step(0, 1, 8'hEE);
        step(0, 0, 8'hDD); step(1, 0, 8'hC2); step(1, 0, 8'hC3);
        step(1, 1, 8'hD0); step(1, 0, 8'hD1);
        settle();
        do_reset();
        // Randomized traffic with mostly-correct framing.
        for (int i = 0; i < 3000; i++) begin
            bit v, fs;
            v  = ($urandom % 4) != 0;
            fs = (mlk && mslot != 0) ? (($urandom % 24) == 0) : (($urandom % 5) != 0);
            step(v, fs, 8'($urandom));
            if (i == 1500) do_reset();
        end
        settle();
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
